// File: rtl/fp_seq_unit_if.sv
// Request/result handshake bundle for fp_seq_unit: operands and opcode in, result out.
interface fp_seq_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  modport master (output in_valid, a, b, op, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  in_valid, a, b, op, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/fp_seq_unit.sv
// Multi-cycle IEEE-754 single add/sub/mul/cmp unit serving one request at a time over valid/ready.
// Build macro FP_SPECIAL_CASE_EN enables NaN/infinity classification and overflow to infinity.
module fp_seq_unit #(
  parameter int WORK_W    = 27,
  parameter int MAX_SHIFT = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_seq_unit_if.slave bus
);
  localparam int         EXT_W       = WORK_W - 24;
  localparam logic [7:0] MAX_SHIFT_E = 8'(MAX_SHIFT);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, MUL, PACK, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [7:0]         ea_q, ea_d, eb_q, eb_d;
  logic [WORK_W-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic               rs_q, rs_d;
  logic signed [10:0] re_q, re_d;
  logic [WORK_W-1:0]  rm_q, rm_d;
  logic [31:0]        result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, busy_q;
  logic               spec_q, spec_d;
  logic [31:0]        spec_val_q, spec_val_d;

  logic [7:0]         diff_ab_s, diff_ba_s;
  logic [WORK_W:0]    sum_s;
  logic [24:0]        prod_hi_s;
  logic signed [10:0] mul_e_s;
  logic [30:0]        mag_a_s, mag_b_s;
  logic               cmp_lt_s, cmp_nan_s, spec_hit_s;
  logic [31:0]        spec_val_s;

  function automatic logic [31:0] overflow_value(input logic sign);
`ifdef FP_SPECIAL_CASE_EN
    return {sign, 8'hFF, 23'h000000};
`else
    return {sign, 8'hFE, 23'h7FFFFF};
`endif
  endfunction

  // Exponent 0 flushes the operand to zero; otherwise the hidden 1 is restored.
  function automatic logic [WORK_W-1:0] unpack_mant(input logic [31:0] x);
    if (x[30:23] == 8'h00) return {WORK_W{1'b0}};
    else return {1'b1, x[22:0], {EXT_W{1'b0}}};
  endfunction

`ifdef FP_SPECIAL_CASE_EN
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] special_value(input logic [31:0] x, input logic [31:0] y,
                                                input logic [1:0] opc);
    logic sy, inf_x, inf_y, zero_x, zero_y;
    sy     = y[31] ^ (opc == 2'd1);
    inf_x  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    inf_y  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    zero_x = (x[30:23] == 8'h00);
    zero_y = (y[30:23] == 8'h00);
    if (is_nan(x) || is_nan(y)) return 32'h7FC00000;
    else if (opc == 2'd2) begin
      if ((inf_x && zero_y) || (inf_y && zero_x)) return 32'h7FC00000;
      else return {x[31] ^ y[31], 8'hFF, 23'h000000};
    end
    else if (inf_x && inf_y && (x[31] != sy)) return 32'h7FC00000;
    else if (inf_x) return {x[31], 8'hFF, 23'h000000};
    else return {sy, 8'hFF, 23'h000000};
  endfunction

  assign cmp_nan_s  = is_nan(a_q) || is_nan(b_q);
  assign spec_hit_s = (op_q != 2'd3) && ((a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF));
  assign spec_val_s = special_value(a_q, b_q, op_q);
`else
  assign cmp_nan_s  = 1'b0;
  assign spec_hit_s = 1'b0;
  assign spec_val_s = 32'h00000000;
`endif

  assign diff_ab_s = ea_q - eb_q;
  assign diff_ba_s = eb_q - ea_q;
  assign sum_s     = {1'b0, ma_q} + {1'b0, mb_q};
  assign prod_hi_s = 25'((48'(ma_q[WORK_W-1 -: 24]) * 48'(mb_q[WORK_W-1 -: 24])) >> 23);
  assign mul_e_s   = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q}) - 11'sd127;
  assign mag_a_s   = (a_q[30:23] == 8'h00) ? 31'd0 : a_q[30:0];
  assign mag_b_s   = (b_q[30:23] == 8'h00) ? 31'd0 : b_q[30:0];

  // Signed-magnitude a<b; both zeros compare equal regardless of sign.
  always_comb begin
    cmp_lt_s = 1'b0;
    if (cmp_nan_s) cmp_lt_s = 1'b0;
    else if ((mag_a_s == 31'd0) && (mag_b_s == 31'd0)) cmp_lt_s = 1'b0;
    else if (a_q[31] != b_q[31]) cmp_lt_s = a_q[31];
    else if (a_q[31] == 1'b0) cmp_lt_s = (mag_a_s < mag_b_s);
    else cmp_lt_s = (mag_a_s > mag_b_s);
  end

  // Sequencer next state and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    rs_d        = rs_q;
    re_d        = re_q;
    rm_d        = rm_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    spec_d      = spec_q;
    spec_val_d  = spec_val_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          state_d = UNPACK;
        end else begin
          state_d = IDLE;
        end
      end
      UNPACK: begin
        sa_d       = a_q[31];
        sb_d       = b_q[31] ^ (op_q == 2'd1);
        ea_d       = a_q[30:23];
        eb_d       = b_q[30:23];
        ma_d       = unpack_mant(a_q);
        mb_d       = unpack_mant(b_q);
        spec_d     = spec_hit_s;
        spec_val_d = spec_val_s;
        if (spec_hit_s) state_d = PACK;
        else if (op_q == 2'd2) state_d = MUL;
        else if (op_q == 2'd3) state_d = PACK;
        else state_d = ALIGN;
      end
      ALIGN: begin
        if (ea_q == eb_q) begin
          state_d = ADDSUB;
        end else if (ea_q < eb_q) begin
          if (diff_ba_s >= MAX_SHIFT_E) begin
            ma_d = {WORK_W{1'b0}};
            ea_d = eb_q;
          end else begin
            ma_d = ma_q >> 1;
            ea_d = ea_q + 8'd1;
          end
        end else begin
          if (diff_ab_s >= MAX_SHIFT_E) begin
            mb_d = {WORK_W{1'b0}};
            eb_d = ea_q;
          end else begin
            mb_d = mb_q >> 1;
            eb_d = eb_q + 8'd1;
          end
        end
      end
      ADDSUB: begin
        re_d = $signed({3'b000, ea_q});
        if (sa_q == sb_q) begin
          rs_d = sa_q;
          if (sum_s[WORK_W]) begin
            rm_d = sum_s[WORK_W:1];
            re_d = $signed({3'b000, ea_q}) + 11'sd1;
          end else begin
            rm_d = sum_s[WORK_W-1:0];
          end
        end else if (ma_q >= mb_q) begin
          rs_d = sa_q;
          rm_d = ma_q - mb_q;
        end else begin
          rs_d = sb_q;
          rm_d = mb_q - ma_q;
        end
        if (rm_d == {WORK_W{1'b0}}) begin
          rs_d    = 1'b0;
          re_d    = 11'sd0;
          state_d = PACK;
        end else if (rm_d[WORK_W-1]) begin
          state_d = PACK;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (re_q <= 11'sd1) begin
          rs_d    = 1'b0;
          re_d    = 11'sd0;
          rm_d    = {WORK_W{1'b0}};
          state_d = PACK;
        end else begin
          rm_d    = rm_q << 1;
          re_d    = re_q - 11'sd1;
          state_d = rm_q[WORK_W-2] ? PACK : NORM;
        end
      end
      MUL: begin
        state_d = PACK;
        if (!ma_q[WORK_W-1] || !mb_q[WORK_W-1]) begin
          rs_d = 1'b0;
          re_d = 11'sd0;
          rm_d = {WORK_W{1'b0}};
        end else if (prod_hi_s[24]) begin
          rs_d = sa_q ^ sb_q;
          re_d = mul_e_s + 11'sd1;
          rm_d = {prod_hi_s[24:1], {EXT_W{1'b0}}};
        end else begin
          rs_d = sa_q ^ sb_q;
          re_d = mul_e_s;
          rm_d = {prod_hi_s[23:0], {EXT_W{1'b0}}};
        end
      end
      PACK: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (op_q == 2'd3) result_d = {31'd0, cmp_lt_s};
        else if (spec_q) result_d = spec_val_q;
        else if (!rm_q[WORK_W-1]) result_d = 32'h00000000;
        else if (re_q >= 11'sd255) result_d = overflow_value(rs_q);
        else if (re_q < 11'sd1) result_d = 32'h00000000;
        else result_d = {rs_q, re_q[7:0], rm_q[WORK_W-2 -: 23]};
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Registers; reset drops any operation in flight without producing a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 32'h00000000;
      b_q         <= 32'h00000000;
      op_q        <= 2'd0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ea_q        <= 8'd0;
      eb_q        <= 8'd0;
      ma_q        <= {WORK_W{1'b0}};
      mb_q        <= {WORK_W{1'b0}};
      rs_q        <= 1'b0;
      re_q        <= 11'sd0;
      rm_q        <= {WORK_W{1'b0}};
      result_q    <= 32'h00000000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= 32'h00000000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      rs_q        <= rs_d;
      re_q        <= re_d;
      rm_q        <= rm_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
endmodule
